dma_mem_responder: RTL and testbench

Memory-backed responder for the decompressor's DMA request interface: services read bursts (compressed input) and write bursts (decompressed output) issued by the AXI I/O top level. It stores bus words in an internal dual-port memory so the full decompress path can run end-to-end in simulation and on-board self-test. It also provides a preload port for the compressed payload and error flags for protocol violations.

---
 rtl/dma_mem_responder_if.sv | 40 ++++
 rtl/dma_mem_responder.sv | 272 +++++++++++++++++++++++++++
 tb/tb_dma_mem_responder.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_mem_responder_if.sv
// Burst request and data channels between a DMA initiator (master) and the memory responder (slave).
// Read channel: request/ack plus a valid/taken beat stream; write channel: request/ack, beats, and a response.
interface dma_mem_responder_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512
);
    logic                    rd_req;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [7:0]              rd_len;
    logic                    rd_req_ack;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_data_valid;
    logic                    rd_data_taken;

    logic                    wr_req;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [7:0]              wr_len;
    logic                    wr_req_ack;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    wr_wvalid;
    logic [DATA_WIDTH/8-1:0] wr_strobe;
    logic                    wr_last;
    logic                    wr_ready;
    logic                    wr_bready;
    logic                    wr_done;

    modport master (
        output rd_req, rd_addr, rd_len, rd_data_taken,
        output wr_req, wr_addr, wr_len, wr_data, wr_wvalid, wr_strobe, wr_last, wr_bready,
        input  rd_req_ack, rd_data, rd_data_valid,
        input  wr_req_ack, wr_ready, wr_done
    );

    modport slave (
        input  rd_req, rd_addr, rd_len, rd_data_taken,
        input  wr_req, wr_addr, wr_len, wr_data, wr_wvalid, wr_strobe, wr_last, wr_bready,
        output rd_req_ack, rd_data, rd_data_valid,
        output wr_req_ack, wr_ready, wr_done
    );
endinterface

// File: rtl/dma_mem_responder.sv
// Memory-backed responder for DMA read/write bursts with a backdoor preload port and sticky error flags.
// Optional pseudo-random stall injection on both channels: define DMA_RESP_BACKPRESSURE_EN.
module dma_mem_responder #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 512,
    parameter int MEM_DEPTH_LOG2 = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    dma_mem_responder_if.slave        bus,
    input  logic                      ld_en,
    input  logic [MEM_DEPTH_LOG2-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0]     ld_data,
    output logic                      err_unaligned,
    output logic                      err_last
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

    typedef logic [MEM_DEPTH_LOG2-1:0] idx_t;
    typedef enum logic [1:0] {RD_IDLE, RD_ACK, RD_DATA} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_ACK, WR_DATA, WR_RESP} wr_state_t;

    // Request address decode: byte offset within a word is ignored apart from the error flag.
    idx_t rd_req_idx;
    idx_t wr_req_idx;
    logic rd_unal;
    logic wr_unal;
    logic unused_addr_bits;

    assign rd_req_idx       = bus.rd_addr[LSB +: MEM_DEPTH_LOG2];
    assign wr_req_idx       = bus.wr_addr[LSB +: MEM_DEPTH_LOG2];
    assign rd_unal          = |bus.rd_addr[LSB-1:0];
    assign wr_unal          = |bus.wr_addr[LSB-1:0];
    assign unused_addr_bits = ^{bus.rd_addr[ADDR_WIDTH-1:LSB+MEM_DEPTH_LOG2],
                                bus.wr_addr[ADDR_WIDTH-1:LSB+MEM_DEPTH_LOG2]};

    // ------------------------------------------------------------------
    // Stall source
    // ------------------------------------------------------------------
    logic stall;
    logic stall_next;

`ifdef DMA_RESP_BACKPRESSURE_EN
    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;

    assign lfsr_next  = {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};
    assign stall      = (lfsr_reg[1:0] == 2'b00);
    assign stall_next = (lfsr_next[1:0] == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= 16'hACE1;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end
`else
    assign stall      = 1'b0;
    assign stall_next = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rd_state_t             rd_state_reg;
    logic                  rd_req_ack_reg;
    idx_t                  rd_issue_idx_reg;
    logic [8:0]            rd_issue_left_reg;
    logic [8:0]            rd_beat_left_reg;
    logic                  s1_valid_reg;
    logic                  out_valid_reg;
    logic [DATA_WIDTH-1:0] out_data_reg;
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  out_fire;
    logic                  out_free;
    logic                  s1_move;
    logic                  ram_re;

    // The RAM output (stage 1) only advances when its current word can move into the
    // output register, so a stalled beat is simply held in the RAM read latch.
    always_comb begin
        out_fire = out_valid_reg && bus.rd_data_taken;
        out_free = !out_valid_reg || out_fire;
        s1_move  = s1_valid_reg && out_free && !stall;
        ram_re   = (rd_state_reg != RD_IDLE) && (rd_issue_left_reg != 9'd0)
                   && (!s1_valid_reg || s1_move);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_reg      <= RD_IDLE;
            rd_req_ack_reg    <= 1'b0;
            rd_issue_idx_reg  <= '0;
            rd_issue_left_reg <= '0;
            rd_beat_left_reg  <= '0;
            s1_valid_reg      <= 1'b0;
            out_valid_reg     <= 1'b0;
            out_data_reg      <= '0;
        end else begin
            rd_req_ack_reg <= 1'b0;
            case (rd_state_reg)
                RD_IDLE: begin
                    if (bus.rd_req) begin
                        rd_state_reg      <= RD_ACK;
                        rd_req_ack_reg    <= 1'b1;
                        rd_issue_idx_reg  <= rd_req_idx;
                        rd_issue_left_reg <= {1'b0, bus.rd_len} + 9'd1;
                        rd_beat_left_reg  <= {1'b0, bus.rd_len} + 9'd1;
                    end
                end
                RD_ACK: begin
                    rd_state_reg <= RD_DATA;
                end
                RD_DATA: begin
                    if (out_fire && (rd_beat_left_reg == 9'd1)) begin
                        rd_state_reg <= RD_IDLE;
                    end
                end
                default: rd_state_reg <= RD_IDLE;
            endcase

            if (ram_re) begin
                rd_issue_idx_reg  <= rd_issue_idx_reg + idx_t'(1);
                rd_issue_left_reg <= rd_issue_left_reg - 9'd1;
            end

            if (ram_re) begin
                s1_valid_reg <= 1'b1;
            end else if (s1_move) begin
                s1_valid_reg <= 1'b0;
            end

            if (s1_move) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= ram_q;
            end else if (out_fire) begin
                out_valid_reg <= 1'b0;
            end

            if (out_fire) begin
                rd_beat_left_reg <= rd_beat_left_reg - 9'd1;
            end
        end
    end

    assign bus.rd_req_ack    = rd_req_ack_reg;
    assign bus.rd_data_valid = out_valid_reg;
    assign bus.rd_data       = out_data_reg;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wr_state_t  wr_state_reg;
    logic       wr_req_ack_reg;
    logic       wr_ready_reg;
    logic       wr_done_reg;
    idx_t       wr_idx_reg;
    logic [7:0] wr_len_reg;
    logic [8:0] wr_cnt_reg;
    logic       err_last_reg;
    logic       wr_beat;
    logic       wr_final;

    assign wr_beat  = bus.wr_wvalid && wr_ready_reg;
    assign wr_final = wr_beat && (wr_cnt_reg == {1'b0, wr_len_reg});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_reg   <= WR_IDLE;
            wr_req_ack_reg <= 1'b0;
            wr_ready_reg   <= 1'b0;
            wr_done_reg    <= 1'b0;
            wr_idx_reg     <= '0;
            wr_len_reg     <= '0;
            wr_cnt_reg     <= '0;
            err_last_reg   <= 1'b0;
        end else begin
            wr_req_ack_reg <= 1'b0;
            case (wr_state_reg)
                WR_IDLE: begin
                    if (bus.wr_req) begin
                        wr_state_reg   <= WR_ACK;
                        wr_req_ack_reg <= 1'b1;
                        wr_idx_reg     <= wr_req_idx;
                        wr_len_reg     <= bus.wr_len;
                        wr_cnt_reg     <= '0;
                    end
                end
                WR_ACK: begin
                    wr_state_reg <= WR_DATA;
                    wr_ready_reg <= !stall_next;
                end
                WR_DATA: begin
                    wr_ready_reg <= !stall_next;
                    if (wr_beat) begin
                        wr_idx_reg <= wr_idx_reg + idx_t'(1);
                        wr_cnt_reg <= wr_cnt_reg + 9'd1;
                        // wr_last must appear exactly on the beat that completes the count.
                        if (wr_final) begin
                            wr_state_reg <= WR_RESP;
                            wr_ready_reg <= 1'b0;
                            wr_done_reg  <= 1'b1;
                            if (!bus.wr_last) begin
                                err_last_reg <= 1'b1;
                            end
                        end else if (bus.wr_last) begin
                            err_last_reg <= 1'b1;
                        end
                    end
                end
                WR_RESP: begin
                    if (bus.wr_bready) begin
                        wr_done_reg  <= 1'b0;
                        wr_state_reg <= WR_IDLE;
                    end
                end
                default: wr_state_reg <= WR_IDLE;
            endcase
        end
    end

    assign bus.wr_req_ack = wr_req_ack_reg;
    assign bus.wr_ready   = wr_ready_reg;
    assign bus.wr_done    = wr_done_reg;

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
    logic err_unaligned_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_unaligned_reg <= 1'b0;
        end else if ((rd_state_reg == RD_IDLE && bus.rd_req && rd_unal)
                  || (wr_state_reg == WR_IDLE && bus.wr_req && wr_unal)) begin
            err_unaligned_reg <= 1'b1;
        end
    end

    assign err_unaligned = err_unaligned_reg;
    assign err_last      = err_last_reg;

    // ------------------------------------------------------------------
    // Word memory, one byte-wide array per lane so strobed writes stay simple.
    // Read-first: the read latch samples the old word on a same-cycle write.
    // The preload write is applied last so it wins on a same-word collision.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_q;

            always_ff @(posedge clk) begin
                if (ram_re) begin
                    lane_q <= lane_mem[rd_issue_idx_reg];
                end
                if (wr_beat && bus.wr_strobe[gi]) begin
                    lane_mem[wr_idx_reg] <= bus.wr_data[gi*8 +: 8];
                end
                if (ld_en) begin
                    lane_mem[ld_addr] <= ld_data[gi*8 +: 8];
                end
            end

            assign ram_q[gi*8 +: 8] = lane_q;
        end
    endgenerate
endmodule

// File: tb/tb_dma_mem_responder.sv
// Directed-plus-random bench for dma_mem_responder against a word-array model of the memory.
// Checks handshake latency, beat ordering, hold-until-taken, byte strobes, wrap, error flags and reset.
module tb_dma_mem_responder;
    localparam int AW    = 64;
    localparam int DW    = 512;
    localparam int DL    = 10;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << DL;
    localparam int BUDGET = 2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dma_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    logic          ld_en;
    logic [DL-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          err_unaligned;
    logic          err_last;

    dma_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH_LOG2(DL)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .ld_en         (ld_en),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
        .err_unaligned (err_unaligned),
        .err_last      (err_last)
    );

    logic [DW-1:0] model [DEPTH];
    logic          model_err_unal;
    logic          model_err_last;
    int            tests = 0;
    int            fails = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [DW-1:0] d);
        ld_en   = 1'b1;
        ld_addr = idx[DL-1:0];
        ld_data = d;
        tick();
        ld_en = 1'b0;
        model[idx] = d;
    endtask

    // mode 0: taken held high, 1: taken on even cycles, 2: random taken
    task automatic do_read(input logic [AW-1:0] addr, input int len, input int mode);
        int            idx;
        int            got;
        int            cyc;
        logic          tk;
        logic          seen;
        logic          prev_hold;
        logic [DW-1:0] prev_data;
        idx = int'(addr[DL+5:6]);
        got = 0;
        cyc = 1;
        seen = 1'b0;
        prev_hold = 1'b0;
        prev_data = '0;
        if (addr[5:0] != 6'd0) model_err_unal = 1'b1;
        $display("[TB] read  addr=%0h len=%0d mode=%0d", addr, len, mode);
        bus.rd_req  = 1'b1;
        bus.rd_addr = addr;
        bus.rd_len  = len[7:0];
        tick();
        check("rd_ack", bus.rd_req_ack, 1);
        bus.rd_req = 1'b0;
        while (got < len + 1 && cyc < BUDGET) begin
            tk = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            bus.rd_data_taken = tk;
            if (cyc == 2) check("rd_ack_pulse", bus.rd_req_ack, 0);
            if (prev_hold) begin
                check("rd_hold_valid", bus.rd_data_valid, 1);
                check("rd_hold_data", bus.rd_data, prev_data);
            end
            if (bus.rd_data_valid) begin
                if (!seen) check("rd_first_lat", cyc, 3);
                seen = 1'b1;
                if (mode == 0) check("rd_beat_cyc", cyc, 3 + got);
                if (tk) begin
                    check("rd_data", bus.rd_data, model[(idx + got) % DEPTH]);
                    got++;
                    prev_hold = 1'b0;
                end else begin
                    prev_hold = 1'b1;
                    prev_data = bus.rd_data;
                end
            end
            tick();
            cyc++;
        end
        bus.rd_data_taken = 1'b0;
        check("rd_beats", got, len + 1);
        check("rd_valid_after", bus.rd_data_valid, 0);
        check("err_unaligned", err_unaligned, model_err_unal);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input int len, input int last_at,
                            input logic [NB-1:0] sa, input logic [NB-1:0] sb,
                            input logic rnd, input int bready_delay);
        int            idx;
        int            beat;
        int            cyc;
        logic [DW-1:0] d;
        logic [DW-1:0] tmp;
        logic [NB-1:0] s;
        idx = int'(addr[DL+5:6]);
        beat = 0;
        cyc = 0;
        if (addr[5:0] != 6'd0) model_err_unal = 1'b1;
        if (last_at != len) model_err_last = 1'b1;
        $display("[TB] write addr=%0h len=%0d last_at=%0d", addr, len, last_at);
        bus.wr_req  = 1'b1;
        bus.wr_addr = addr;
        bus.wr_len  = len[7:0];
        tick();
        check("wr_ack", bus.wr_req_ack, 1);
        bus.wr_req = 1'b0;
        tick();
        check("wr_ready_t2", bus.wr_ready, 1);
        while (beat <= len && cyc < BUDGET) begin
            d = rand_word();
            s = rnd ? {$urandom, $urandom} : ((beat == 0) ? sa : sb);
            bus.wr_wvalid = 1'b1;
            bus.wr_data   = d;
            bus.wr_strobe = s;
            bus.wr_last   = (beat == last_at);
            while (!bus.wr_ready && cyc < BUDGET) begin
                tick();
                cyc++;
            end
            tick();
            cyc++;
            tmp = model[(idx + beat) % DEPTH];
            for (int b = 0; b < NB; b++) if (s[b]) tmp[b*8 +: 8] = d[b*8 +: 8];
            model[(idx + beat) % DEPTH] = tmp;
            beat++;
            bus.wr_wvalid = 1'b0;
            bus.wr_last   = 1'b0;
            if (beat <= len && rnd && ($urandom_range(0, 1) == 1)) begin
                tick();
                cyc++;
            end
        end
        check("wr_in_budget", (cyc < BUDGET), 1);
        check("wr_done", bus.wr_done, 1);
        check("wr_ready_resp", bus.wr_ready, 0);
        for (int i = 0; i < bready_delay; i++) begin
            tick();
            check("wr_done_hold", bus.wr_done, 1);
        end
        bus.wr_bready = 1'b1;
        tick();
        bus.wr_bready = 1'b0;
        check("wr_done_clear", bus.wr_done, 0);
        check("err_last", err_last, model_err_last);
    endtask

    initial begin
        logic [AW-1:0] a;
        int            ln;
        logic [DW-1:0] w;

        bus.rd_req = 1'b0; bus.rd_addr = '0; bus.rd_len = '0; bus.rd_data_taken = 1'b0;
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_len = '0; bus.wr_data = '0;
        bus.wr_wvalid = 1'b0; bus.wr_strobe = '0; bus.wr_last = 1'b0; bus.wr_bready = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        model_err_unal = 1'b0;
        model_err_last = 1'b0;

        repeat (2) tick();
        check("rst_rd_ack", bus.rd_req_ack, 0);
        check("rst_rd_valid", bus.rd_data_valid, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_wr_ack", bus.wr_req_ack, 0);
        check("rst_wr_ready", bus.wr_ready, 0);
        check("rst_wr_done", bus.wr_done, 0);
        check("rst_err_unal", err_unaligned, 0);
        check("rst_err_last", err_last, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < DEPTH; i++) preload(i, rand_word());
        for (int i = 0; i < 4; i++) begin
            w = rand_word();
            w[7:0] = 8'(i);
            preload(i, w);
        end

        do_read(64'h0, 3, 0);

        do_write(64'h40, 1, 1, {NB{1'b1}}, {(NB/8){8'h0F}}, 1'b0, 2);
        do_read(64'h40, 1, 0);

        do_read(64'h0, 3, 1);

        do_read(64'(1023 * 64), 1, 0);
        do_write(64'(1022 * 64), 2, 2, {NB{1'b1}}, {NB{1'b1}}, 1'b0, 0);
        do_read(64'(1022 * 64), 3, 0);

        for (int k = 0; k < 6; k++) begin
            a  = 64'($urandom_range(0, DEPTH - 1)) << 6;
            ln = $urandom_range(0, 15);
            do_write(a, ln, ln, '0, '0, 1'b1, $urandom_range(0, 3));
            do_read(a, ln, 2);
            do_read(64'($urandom_range(0, DEPTH - 1)) << 6, $urandom_range(0, 7), 2);
        end

        do_write(64'h1000, 2, 1, {NB{1'b1}}, {NB{1'b1}}, 1'b0, 0);
        do_read(64'h41, 0, 0);
        do_write(64'h2000, 0, 0, {NB{1'b1}}, {NB{1'b1}}, 1'b0, 0);
        check("err_last_sticky", err_last, 1);

        for (int i = 192; i < 196; i++) preload(i, rand_word());
        bus.wr_req = 1'b1; bus.wr_addr = 64'h3000; bus.wr_len = 8'd3;
        tick();
        bus.wr_req = 1'b0;
        tick();
        for (int b = 0; b < 2; b++) begin
            w = rand_word();
            bus.wr_wvalid = 1'b1; bus.wr_data = w; bus.wr_strobe = {NB{1'b1}}; bus.wr_last = 1'b0;
            tick();
            model[192 + b] = w;
        end
        bus.wr_data = rand_word();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_wr_ready", bus.wr_ready, 0);
        check("arst_wr_done", bus.wr_done, 0);
        check("arst_err_unal", err_unaligned, 0);
        check("arst_err_last", err_last, 0);
        check("arst_rd_valid", bus.rd_data_valid, 0);
        bus.wr_wvalid = 1'b0;
        model_err_unal = 1'b0;
        model_err_last = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        do_write(64'h3080, 0, 0, {NB{1'b1}}, {NB{1'b1}}, 1'b0, 1);
        do_read(64'h3000, 3, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
